register_formatter: RTL and testbench

REGISTER_FORMATTER -- requirements
Module: register_formatter

---
 rtl/register_formatter.sv | 134 +++++++++++++
 tb/tb_register_formatter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/register_formatter.sv
// register_formatter
//   Turns a 5-bit register number into the 4-character ASCII token
//   <prefix><tens><ones><delim>, e.g. 7 -> "r07 ", 31 -> "r31,".
//   The digits always have a leading zero, so the token is always legal
//   input to the register parser. One character is offered per cycle on a
//   valid/ready stream. The next request can be taken on the delimiter
//   handshake, so back-to-back tokens form a continuous stream.
//
// Parameters
//   UPPERCASE  0 -> prefix "r" (0x72), 1 -> prefix "R" (0x52)
//
// Ports
//   clk_in     in   1  clock; all state changes on the rising edge
//   rst_in     in   1  synchronous active-high reset
//   in_valid   in   1  a register number is offered
//   register   in   5  register number 0-31
//   delim_sel  in   1  delimiter: 0 -> " ", 1 -> ","
//   in_ready   out  1  request is accepted this cycle if in_valid
//   out_valid  out  1  out_char holds a character
//   out_char   out  8  ASCII character, 0x00 when idle
//   out_ready  in   1  downstream takes out_char this cycle
//   done_flag  out  1  high on the cycle the delimiter is consumed
module register_formatter #(
  parameter bit UPPERCASE = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       in_valid,
  input  logic [4:0] register,
  input  logic       delim_sel,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_char,
  input  logic       out_ready,
  output logic       done_flag
);

  typedef enum logic [2:0] {
    IDLE,
    EMIT_PREFIX,
    EMIT_TENS,
    EMIT_ONES,
    EMIT_DELIM
  } state_t;

  localparam logic [7:0] PREFIX_CHAR = UPPERCASE ? 8'h52 : 8'h72;

  state_t     state, state_nxt;
  logic [4:0] reg_q;
  logic       delim_q;
  logic       accept;
  logic [1:0] tens;
  logic [4:0] tens_x10;
  logic [3:0] ones;

  // Decimal split by range compare. Only the low nibble of the subtraction
  // matters because the remainder is always below 10, so the subtraction
  // is done modulo 16.
  always_comb begin
    tens     = 2'd0;
    tens_x10 = 5'd0;
    if (reg_q >= 5'd30) begin
      tens     = 2'd3;
      tens_x10 = 5'd30;
    end else if (reg_q >= 5'd20) begin
      tens     = 2'd2;
      tens_x10 = 5'd20;
    end else if (reg_q >= 5'd10) begin
      tens     = 2'd1;
      tens_x10 = 5'd10;
    end
    ones = reg_q[3:0] - tens_x10[3:0];
  end

  // Next state and outputs. out_char is built only from the state register
  // and the latched request, so it cannot glitch with the live inputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;
    done_flag = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EMIT_PREFIX;
      end
      EMIT_PREFIX: begin
        out_valid = 1'b1;
        out_char  = PREFIX_CHAR;
        if (out_ready) state_nxt = EMIT_TENS;
      end
      EMIT_TENS: begin
        out_valid = 1'b1;
        out_char  = 8'h30 | {6'd0, tens};
        if (out_ready) state_nxt = EMIT_ONES;
      end
      EMIT_ONES: begin
        out_valid = 1'b1;
        out_char  = 8'h30 | {4'd0, ones};
        if (out_ready) state_nxt = EMIT_DELIM;
      end
      EMIT_DELIM: begin
        out_valid = 1'b1;
        out_char  = delim_q ? 8'h2C : 8'h20;
        // The next request may enter on the delimiter handshake, so a
        // new token starts on the very next cycle.
        in_ready  = out_ready;
        done_flag = out_ready;
        if (out_ready) state_nxt = in_valid ? EMIT_PREFIX : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Reset takes priority over accept: a request offered while reset is
  // asserted is dropped, and an interrupted token does not resume.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      reg_q   <= 5'd0;
      delim_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        reg_q   <= register;
        delim_q <= delim_sel;
      end
    end
  end

endmodule

// File: tb/tb_register_formatter.sv
module tb_register_formatter;

  logic       clk_in = 1'b0;
  logic       rst_in, in_valid, delim_sel, out_ready;
  logic [4:0] register;
  logic       ir0, ov0, df0, ir1, ov1, df1;
  logic [7:0] oc0, oc1;

  always #5 clk_in = ~clk_in;

  register_formatter #(.UPPERCASE(1'b0)) u_lc (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .register(register),
    .delim_sel(delim_sel), .in_ready(ir0), .out_valid(ov0), .out_char(oc0),
    .out_ready(out_ready), .done_flag(df0));

  register_formatter #(.UPPERCASE(1'b1)) u_uc (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .register(register),
    .delim_sel(delim_sel), .in_ready(ir1), .out_valid(ov1), .out_char(oc1),
    .out_ready(out_ready), .done_flag(df1));

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of pending characters, each tagged with its
  // position inside its 4-character token.
  typedef struct {
    logic [4:0] r;
    logic       d;
    int         pos;
  } ent_t;
  ent_t  q[$];
  string s0, s1;
  int    done0, done1;
  bit    acc;

  function automatic logic [7:0] model_char(ent_t e, bit upper);
    case (e.pos)
      0:       return upper ? 8'h52 : 8'h72;
      1:       return 8'h30 + 8'(int'(e.r) / 10);
      2:       return 8'h30 + 8'(int'(e.r) % 10);
      default: return e.d ? 8'h2C : 8'h20;
    endcase
  endfunction

  // Independent parser: returns 1 on a malformed token.
  function automatic bit parse_reg(string s, int base, output int val);
    byte c0, c1, c2, c3;
    int  t, o;
    val = -1;
    if (s.len() < base + 4) return 1'b1;
    c0 = s[base]; c1 = s[base+1]; c2 = s[base+2]; c3 = s[base+3];
    if (c0 != 8'h72 && c0 != 8'h52) return 1'b1;
    t = int'(c1) - 48;
    o = int'(c2) - 48;
    if (t < 0 || t > 3 || o < 0 || o > 9) return 1'b1;
    if (c3 != 8'h20 && c3 != 8'h2C) return 1'b1;
    val = t * 10 + o;
    return (val > 31);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(string tag, string obs, string exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, obs, exp);
    end
  endtask

  task automatic clr();
    s0 = ""; s1 = ""; done0 = 0; done1 = 0;
  endtask

  // One clock cycle: drive inputs just after the falling edge, check the
  // outputs against the model, then advance the model across the rising edge.
  task automatic cyc(bit rst, bit iv, logic [4:0] rg, bit dl, bit ordy);
    bit         ev, ed, eir;
    logic [7:0] e0, e1;
    rst_in = rst; in_valid = iv; register = rg; delim_sel = dl; out_ready = ordy;
    #1;
    ev  = (q.size() != 0);
    e0  = ev ? model_char(q[0], 1'b0) : 8'h00;
    e1  = ev ? model_char(q[0], 1'b1) : 8'h00;
    ed  = ev && (q[0].pos == 3) && ordy;
    eir = !ev || ((q[0].pos == 3) && ordy);
    chk("out_valid_lc", 32'(ov0), 32'(ev));
    chk("out_char_lc",  32'(oc0), 32'(e0));
    chk("done_flag_lc", 32'(df0), 32'(ed));
    chk("in_ready_lc",  32'(ir0), 32'(eir));
    chk("out_valid_uc", 32'(ov1), 32'(ev));
    chk("out_char_uc",  32'(oc1), 32'(e1));
    chk("done_flag_uc", 32'(df1), 32'(ed));
    chk("in_ready_uc",  32'(ir1), 32'(eir));
    if (df0) done0++;
    if (df1) done1++;
    acc = 1'b0;
    if (rst) q.delete();
    else begin
      if (ev && ordy) begin
        s0 = {s0, $sformatf("%c", oc0)};
        s1 = {s1, $sformatf("%c", oc1)};
        void'(q.pop_front());
      end
      if (eir && iv) begin
        for (int p = 0; p < 4; p++) q.push_back('{r: rg, d: dl, pos: p});
        acc = 1'b1;
      end
    end
    @(negedge clk_in);
  endtask

  initial begin
    int r, budget, val;
    bit err;
    rst_in = 1'b1; in_valid = 1'b0; register = 5'd0; delim_sel = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk_in);

    // Reset state; a request during reset is ignored.
    cyc(1, 1, 5'd9, 0, 1);
    cyc(0, 0, 5'd0, 0, 1);

    // Single request, no stall.
    clr();
    cyc(0, 1, 5'd7, 0, 1);
    repeat (5) cyc(0, 0, 5'd0, 0, 1);
    chk_str("single_lc", s0, "r07 ");
    chk_str("single_uc", s1, "R07 ");
    chk("single_done", 32'(done0), 32'd1);

    // Backpressure: 3 stall cycles per character, busy inputs wiggling.
    clr();
    cyc(0, 1, 5'd31, 1, 0);
    for (int c = 0; c < 4; c++) begin
      repeat (3) cyc(0, 1, 5'($urandom), 1'($urandom), 0);
      cyc(0, c != 3, 5'($urandom), 1'($urandom), 1);
    end
    cyc(0, 0, 5'd0, 0, 1);
    chk_str("stall_lc", s0, "r31,");
    chk_str("stall_uc", s1, "R31,");

    // Back-to-back, zero bubble.
    clr();
    cyc(0, 1, 5'd0, 0, 1);
    repeat (4) cyc(0, 1, 5'd30, 0, 1);
    repeat (5) cyc(0, 0, 5'd0, 0, 1);
    chk_str("b2b_lc", s0, "r00 r30 ");
    chk("b2b_done", 32'(done0), 32'd2);

    // Reset in EMIT_TENS of 19, then a fresh request for 5.
    clr();
    cyc(0, 1, 5'd19, 0, 1);
    cyc(0, 0, 5'd0, 0, 1);
    cyc(1, 1, 5'd19, 0, 1);
    cyc(0, 0, 5'd0, 0, 1);
    clr();
    cyc(0, 1, 5'd5, 0, 1);
    repeat (5) cyc(0, 0, 5'd0, 0, 1);
    chk_str("after_rst_lc", s0, "r05 ");

    // Busy handling: 3 is offered while 12 is still being emitted.
    clr();
    cyc(0, 1, 5'd12, 0, 1);
    repeat (4) cyc(0, 1, 5'd3, 0, 1);
    repeat (5) cyc(0, 0, 5'd0, 0, 1);
    chk_str("busy_lc", s0, "r12 r03 ");
    chk_str("busy_uc", s1, "R12 R03 ");

    // Random traffic with random backpressure and occasional reset.
    repeat (400)
      cyc($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), 5'($urandom),
          1'($urandom), $urandom_range(0, 3) != 0);
    cyc(1, 0, 5'd0, 0, 1);

    // Sweep 0..31 back-to-back and parse the result.
    clr();
    r = 0;
    budget = 0;
    while (r < 32 && budget < 500) begin
      cyc(0, 1, 5'(r), 1'(r % 2), 1);
      if (acc) r++;
      budget++;
    end
    chk("sweep_accepts", 32'(r), 32'd32);
    repeat (5) cyc(0, 0, 5'd0, 0, 1);
    chk("sweep_len", 32'(s0.len()), 32'd128);
    for (int i = 0; i < 32; i++) begin
      err = parse_reg(s0, 4 * i, val);
      chk("sweep_parse_err", 32'(err), 32'd0);
      chk("sweep_parse_val", 32'(val), 32'(i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
